// File: rtl/sync_fifo_lvl.sv
// ---------------------------------------------------------------------------
// sync_fifo_lvl
//
// Single-clock FIFO with fill-level count, programmable almost-full and
// almost-empty thresholds, sticky overflow/underflow flags and a synchronous
// flush. Storage is an internal register array of depth 2**add_size.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//    defined   -> first-word-fall-through, data_out shows the head word
//                 combinationally whenever the FIFO is not empty
//    undefined -> registered read, data_out updates one edge after an
//                 accepted read and holds until the next one
//
// Ports:
//    clk          in   rising-edge clock
//    rst          in   asynchronous active-low reset
//    data_in      in   write data
//    wr_inc       in   write request
//    rd_inc       in   read request
//    flush        in   synchronous clear of contents
//    err_clr      in   synchronous clear of sticky error flags
//    data_out     out  read data
//    full         out  fifo holds depth words
//    empty        out  fifo holds no words
//    almost_full  out  free slots <= af_level
//    almost_empty out  stored words <= ae_level
//    fill_count   out  stored word count, 0..depth
//    overflow     out  sticky, write attempted while full
//    underflow    out  sticky, read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_lvl #(
   parameter int data_size = 8,
   parameter int add_size  = 4,
   parameter int af_level  = 2,
   parameter int ae_level  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_size-1:0]  data_in,
   input  logic                  wr_inc,
   input  logic                  rd_inc,
   input  logic                  flush,
   input  logic                  err_clr,
   output logic [data_size-1:0]  data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [add_size:0]     fill_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << add_size;
   localparam logic [add_size:0] DEPTH_C = (add_size+1)'(DEPTH);
   localparam logic [add_size:0] AF_C    = (add_size+1)'(af_level);
   localparam logic [add_size:0] AE_C    = (add_size+1)'(ae_level);

   // Thresholds beyond the depth make the flags meaningless, so refuse to
   // elaborate rather than silently truncating them.
   if (af_level < 0 || af_level > DEPTH || ae_level < 0 || ae_level > DEPTH) begin : g_badLevel
      $error("sync_fifo_lvl: af_level/ae_level must lie in 0..2**add_size");
   end

   logic [data_size-1:0] mem [DEPTH];

   logic [add_size:0]   wrPtr_q, wrPtr_d;
   logic [add_size:0]   rdPtr_q, rdPtr_d;
   logic [add_size:0]   count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;

   logic [add_size-1:0] wrAddr;
   logic [add_size-1:0] rdAddr;
   logic                fullInt;
   logic                emptyInt;
   logic                wrAccept;
   logic                rdAccept;

   // The pointers carry one extra wrap bit so that equal addresses can be
   // told apart as either completely full or completely empty.
   assign wrAddr   = wrPtr_q[add_size-1:0];
   assign rdAddr   = rdPtr_q[add_size-1:0];
   assign fullInt  = (wrAddr == rdAddr) && (wrPtr_q[add_size] != rdPtr_q[add_size]);
   assign emptyInt = (wrPtr_q == rdPtr_q);

   // A flush overrides any request made in the same cycle.
   assign wrAccept = wr_inc && !fullInt && !flush;
   assign rdAccept = rd_inc && !emptyInt && !flush;

   // Next-state for pointers, fill level and the sticky error flags. The
   // error flags are left alone by a flush; err_clr beats a same-cycle set.
   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (rdAccept) begin
            rdPtr_d = rdPtr_q + 1'b1;
         end
         case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (wr_inc && fullInt) begin
            overflow_d = 1'b1;
         end
         if (rd_inc && emptyInt) begin
            underflow_d = 1'b1;
         end
      end

      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   // State register for pointers, level and error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; deliberately not reset so it can map onto plain flops
   // or distributed RAM without a reset network.
   always_ff @(posedge clk) begin
      if (wrAccept) begin
         mem[wrAddr] <= data_in;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is visible as soon as it is stored; an accepted read simply
   // moves the read pointer on to the next word.
   assign data_out = mem[rdAddr];
`else
   logic [data_size-1:0] dataOut_q, dataOut_d;

   assign dataOut_d = rdAccept ? mem[rdAddr] : dataOut_q;

   // Registered read port: the word leaves the array on the same edge that
   // advances the read pointer and holds until the next accepted read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dataOut_q <= '0;
      end else begin
         dataOut_q <= dataOut_d;
      end
   end

   assign data_out = dataOut_q;
`endif

   // Every status output depends only on registered state.
   assign full         = fullInt;
   assign empty        = emptyInt;
   assign fill_count   = count_q;
   assign almost_full  = (DEPTH_C - count_q) <= AF_C;
   assign almost_empty = count_q <= AE_C;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_lvl
//
// Self-checking bench for sync_fifo_lvl in its default build (depth 16,
// registered read). A short directed vector table is followed by hand
// sequences for fill/drain, flush, wrap-around and asynchronous reset, and
// finally a randomized run compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_sync_fifo_lvl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFL   = 2;
   localparam int AEL   = 2;

   logic          clk;
   logic          rst;
   logic [DW-1:0] dataIn;
   logic          wrInc;
   logic          rdInc;
   logic          flushIn;
   logic          errClr;
   logic [DW-1:0] dataOut;
   logic          fullOut;
   logic          emptyOut;
   logic          almostFull;
   logic          almostEmpty;
   logic [AW:0]   fillCount;
   logic          overflowOut;
   logic          underflowOut;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state: the FIFO contents as a plain queue plus the
   // values the outputs should hold.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] mDout;
   logic          mOv;
   logic          mUn;

   typedef struct {
      logic          wr;
      logic          rd;
      logic          fl;
      logic          ec;
      logic [DW-1:0] din;
      int            cnt;
      logic          f;
      logic          e;
      logic          af;
      logic          ae;
      logic [DW-1:0] d;
      logic          ov;
      logic          un;
   } vec_t;

   vec_t vecs[11];

   sync_fifo_lvl #(
      .data_size (DW),
      .add_size  (AW),
      .af_level  (AFL),
      .ae_level  (AEL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (dataIn),
      .wr_inc       (wrInc),
      .rd_inc       (rdInc),
      .flush        (flushIn),
      .err_clr      (errClr),
      .data_out     (dataOut),
      .full         (fullOut),
      .empty        (emptyOut),
      .almost_full  (almostFull),
      .almost_empty (almostEmpty),
      .fill_count   (fillCount),
      .overflow     (overflowOut),
      .underflow    (underflowOut)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(logic wr, logic rd, logic fl, logic ec, logic [DW-1:0] din,
                                  int cnt, logic f, logic e, logic af, logic ae,
                                  logic [DW-1:0] d, logic ov, logic un);
      vec_t v;
      v.wr = wr; v.rd = rd; v.fl = fl; v.ec = ec; v.din = din;
      v.cnt = cnt; v.f = f; v.e = e; v.af = af; v.ae = ae;
      v.d = d; v.ov = ov; v.un = un;
      return v;
   endfunction

   task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(string tag, int cnt, logic f, logic e, logic af, logic ae,
                              logic [DW-1:0] d, logic ov, logic un);
      checkVal({tag, ".fill_count"},   32'(fillCount),    32'(cnt));
      checkVal({tag, ".full"},         32'(fullOut),      32'(f));
      checkVal({tag, ".empty"},        32'(emptyOut),     32'(e));
      checkVal({tag, ".almost_full"},  32'(almostFull),   32'(af));
      checkVal({tag, ".almost_empty"}, 32'(almostEmpty),  32'(ae));
      checkVal({tag, ".data_out"},     32'(dataOut),      32'(d));
      checkVal({tag, ".overflow"},     32'(overflowOut),  32'(ov));
      checkVal({tag, ".underflow"},    32'(underflowOut), 32'(un));
   endtask

   // Expected outputs derived from the model queue and the flag definitions.
   task automatic checkModel(string tag);
      int n;
      n = mq.size();
      checkOutput(tag, n, n == DEPTH, n == 0, (DEPTH - n) <= AFL, n <= AEL, mDout, mOv, mUn);
   endtask

   // Drive one cycle of inputs, advance the model by the FIFO rules, and
   // return one time unit after the rising edge.
   task automatic applyStimulus(logic wr, logic rd, logic [DW-1:0] din, logic fl, logic ec);
      int n;
      wrInc   = wr;
      rdInc   = rd;
      dataIn  = din;
      flushIn = fl;
      errClr  = ec;
      n = mq.size();
      if (ec) begin
         mOv = 1'b0;
         mUn = 1'b0;
      end else if (!fl) begin
         if (wr && n == DEPTH) mOv = 1'b1;
         if (rd && n == 0)     mUn = 1'b1;
      end
      if (fl) begin
         mq.delete();
      end else begin
         if (rd && n > 0)     mDout = mq.pop_front();
         if (wr && n < DEPTH) mq.push_back(din);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      wrInc = 1'b0; rdInc = 1'b0; flushIn = 1'b0; errClr = 1'b0; dataIn = '0;
   endtask

   // Pull reset low between edges, check outputs before any edge, release.
   task automatic doReset(string tag);
      idleInputs();
      #2 rst = 1'b0;
      #1;
      mq.delete();
      mDout = '0;
      mOv   = 1'b0;
      mUn   = 1'b0;
      checkOutput(tag, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wrPct;
      int rdPct;
      logic [DW-1:0] w;

      idleInputs();
      mDout = '0;
      mOv   = 1'b0;
      mUn   = 1'b0;
      rst   = 1'b0;
      #12 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      // Directed table:  wr rd fl ec din | cnt f e af ae dout ov un
      vecs[0]  = mkVec(1,0,0,0,8'h11, 1,0,0,0,1,8'h00,0,0);
      vecs[1]  = mkVec(1,0,0,0,8'h22, 2,0,0,0,1,8'h00,0,0);
      vecs[2]  = mkVec(1,0,0,0,8'h33, 3,0,0,0,0,8'h00,0,0);
      vecs[3]  = mkVec(1,1,0,0,8'h44, 3,0,0,0,0,8'h11,0,0);
      vecs[4]  = mkVec(0,1,0,0,8'h00, 2,0,0,0,1,8'h22,0,0);
      vecs[5]  = mkVec(0,1,0,0,8'h00, 1,0,0,0,1,8'h33,0,0);
      vecs[6]  = mkVec(0,1,0,0,8'h00, 0,0,1,0,1,8'h44,0,0);
      vecs[7]  = mkVec(0,1,0,0,8'h00, 0,0,1,0,1,8'h44,0,1);
      vecs[8]  = mkVec(1,1,0,0,8'h55, 1,0,0,0,1,8'h44,0,1);
      vecs[9]  = mkVec(0,0,0,1,8'h00, 1,0,0,0,1,8'h44,0,0);
      vecs[10] = mkVec(1,0,1,0,8'h66, 0,0,1,0,1,8'h44,0,0);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].fl, vecs[i].ec);
         checkOutput($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].f, vecs[i].e,
                     vecs[i].af, vecs[i].ae, vecs[i].d, vecs[i].ov, vecs[i].un);
      end

      // Fill to full, then one write too many.
      doReset("reset2");
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
         checkModel($sformatf("fill%0d", i));
         if (i == 13) checkVal("fill13.almost_full", 32'(almostFull), 32'd0);
         if (i == 14) checkVal("fill14.almost_full", 32'(almostFull), 32'd1);
      end
      checkVal("fill.full", 32'(fullOut), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
      checkVal("ovf.overflow", 32'(overflowOut), 32'd1);
      checkVal("ovf.fill_count", 32'(fillCount), 32'd16);

      // Drain in order, then one read too many.
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         checkVal($sformatf("drain%0d.data_out", i), 32'(dataOut), 32'(i));
      end
      checkVal("drain.empty", 32'(emptyOut), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checkVal("udf.underflow", 32'(underflowOut), 32'd1);
      checkVal("udf.data_out", 32'(dataOut), 32'h10);

      // Flush with a same-cycle write; error flags survive, err_clr clears.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, DW'(8'hC0 + i), 1'b0, 1'b0);
      checkVal("pre_flush.fill_count", 32'(fillCount), 32'd5);
      applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
      checkOutput("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("err_clr", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);

      // Steady level of 8 with simultaneous read/write across pointer wrap.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0);
         checkModel($sformatf("steady%0d", i));
      end

      // Asynchronous reset in the middle of a burst at level 9.
      doReset("reset3");
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, DW'(8'h70 + i), 1'b0, 1'b0);
      checkVal("burst.fill_count", 32'(fillCount), 32'd9);
      doReset("reset_mid");
      applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checkVal("post_reset.data_out", 32'(dataOut), 32'h3C);
      checkModel("post_reset");

      // Randomized traffic in phases of differing read/write bias.
      for (int i = 0; i < 400; i++) begin
         case (i / 100)
            0:       begin wrPct = 75; rdPct = 30; end
            1:       begin wrPct = 30; rdPct = 75; end
            2:       begin wrPct = 50; rdPct = 50; end
            default: begin wrPct = 90; rdPct = 10; end
         endcase
         w = DW'($urandom);
         applyStimulus($urandom_range(0, 99) < wrPct, $urandom_range(0, 99) < rdPct, w,
                       $urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0);
         checkModel($sformatf("rand%0d", i));
      end

      idleInputs();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
